// File: rtl/hazard_sequencer.sv
// hazard_sequencer: load-use/redirect/mem-wait pipeline control with Mealy outputs; HAZARD_PERF_EN builds the stall/flush/memwait counters
module hazard_sequencer #(
  parameter int REDIRECT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EX_BranchTaken,
  input  logic        EX_JR,
  input  logic        mem_busy,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        flush,
  output logic        EXMEM_Write,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] memwait_cnt
);
  typedef enum logic [1:0] {RUN, LU_STALL, REDIRECT, MEM_WAIT} state_t;
  state_t state, state_nx, ret_state, ret_nx, eff;
  logic [1:0] rcnt, rcnt_nx;
  logic redirect, lu_hazard, stall_c, flush_c;
  assign redirect  = EX_BranchTaken | EX_JR;
  assign lu_hazard = IDEX_MemRead & (IDEX_Rt != 5'd0) &
                     ((IDEX_Rt == IFID_Rs) | (ID_UsesRt & (IDEX_Rt == IFID_Rt)));
  assign eff = (state == MEM_WAIT) ? ret_state : state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= RUN;
      ret_state <= RUN;
      rcnt      <= 2'd0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      rcnt      <= rcnt_nx;
    end
  always_comb begin
    state_nx = RUN;
    ret_nx   = ret_state;
    rcnt_nx  = rcnt;
    if (mem_busy) begin
      state_nx = MEM_WAIT;
      if (state != MEM_WAIT) ret_nx = state;
    end else if (redirect) begin
      state_nx = (REDIRECT_CYCLES > 1) ? REDIRECT : RUN;
      rcnt_nx  = (REDIRECT_CYCLES > 1) ? 2'(REDIRECT_CYCLES - 1) : rcnt;
    end else if (eff == REDIRECT) begin
      state_nx = (rcnt == 2'd1) ? RUN : REDIRECT;
      rcnt_nx  = rcnt - 2'd1;
    end else if (eff == RUN && lu_hazard) begin
      state_nx = LU_STALL;
    end
  end
  always_comb begin
    stall_c     = reset_n & ~mem_busy & ~redirect & (eff == RUN) & lu_hazard;
    flush_c     = reset_n & ~mem_busy & (redirect | (eff == REDIRECT));
    PC_Write    = reset_n & ~mem_busy & ~stall_c;
    IFID_Write  = reset_n & ~mem_busy & ~stall_c;
    EXMEM_Write = reset_n & ~mem_busy;
    IFID_Flush  = ~reset_n | flush_c;
    flush       = ~reset_n | flush_c | stall_c;
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stall_cnt   <= 16'd0;
      flush_cnt   <= 16'd0;
      memwait_cnt <= 16'd0;
    end else begin
      if (stall_c && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush_c && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      if (mem_busy && memwait_cnt != 16'hFFFF) memwait_cnt <= memwait_cnt + 16'd1;
    end
`else
  assign stall_cnt   = 16'd0;
  assign flush_cnt   = 16'd0;
  assign memwait_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed checks of hazard_sequencer with REDIRECT_CYCLES=3
module tb_hazard_sequencer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic mr = 1'b0, uses = 1'b0, br = 1'b0, jr = 1'b0, mb = 1'b0;
  logic [4:0] irt = 5'd0, rs = 5'd0, rt = 5'd0;
  logic pc_w, ifid_w, ifid_f, fl, exmem_w;
  logic [15:0] stall_cnt, flush_cnt, memwait_cnt;
  int checks = 0, errors = 0;
  hazard_sequencer #(.REDIRECT_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n), .IDEX_MemRead(mr), .IDEX_Rt(irt),
    .IFID_Rs(rs), .IFID_Rt(rt), .ID_UsesRt(uses), .EX_BranchTaken(br),
    .EX_JR(jr), .mem_busy(mb), .PC_Write(pc_w), .IFID_Write(ifid_w),
    .IFID_Flush(ifid_f), .flush(fl), .EXMEM_Write(exmem_w),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );
  always #5 clk = ~clk;
  wire [4:0] outs = {pc_w, ifid_w, exmem_w, ifid_f, fl};
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string tag, input logic m, input logic [4:0] r, input logic [4:0] s,
                      input logic [4:0] t, input logic u, input logic b, input logic j,
                      input logic w, input logic [4:0] exp);
    mr = m; irt = r; rs = s; rt = t; uses = u; br = b; jr = j; mb = w;
    #1;
    check(tag, {11'd0, outs}, {11'd0, exp});
    tick();
  endtask
  task automatic counters(input string tag, input logic [15:0] s, input logic [15:0] f, input logic [15:0] m);
`ifdef HAZARD_PERF_EN
    check({tag, "_stall"}, stall_cnt, s);
    check({tag, "_flush"}, flush_cnt, f);
    check({tag, "_memwait"}, memwait_cnt, m);
`else
    check({tag, "_stall"}, stall_cnt, 16'd0);
    check({tag, "_flush"}, flush_cnt, 16'd0);
    check({tag, "_memwait"}, memwait_cnt, 16'd0);
`endif
  endtask
  // outs = {PC_Write, IFID_Write, EXMEM_Write, IFID_Flush, flush}
  initial begin
    repeat (3) tick();
    check("reset_outs", {11'd0, outs}, 16'b00011);
    counters("reset_cnt", 16'd0, 16'd0, 16'd0);
    reset_n = 1'b1;
    step("first_run",     0, 0, 0, 0, 0, 0, 0, 0, 5'b11100);
    step("lu_rs_stall",   1, 5, 5, 0, 0, 0, 0, 0, 5'b00101);
    step("lu_rs_once",    1, 5, 5, 0, 0, 0, 0, 0, 5'b11100);
    step("lu_rt0_none",   1, 0, 0, 0, 0, 0, 0, 0, 5'b11100);
    step("lu_rt_nouse",   1, 7, 1, 7, 0, 0, 0, 0, 5'b11100);
    step("lu_rt_use",     1, 7, 1, 7, 1, 0, 0, 0, 5'b00101);
    step("lu_rt_after",   0, 0, 0, 0, 0, 0, 0, 0, 5'b11100);
    step("redir_c1",      0, 0, 0, 0, 0, 1, 0, 0, 5'b11111);
    step("redir_c2",      0, 0, 0, 0, 0, 0, 0, 0, 5'b11111);
    step("redir_c3",      0, 0, 0, 0, 0, 0, 0, 0, 5'b11111);
    step("redir_done",    0, 0, 0, 0, 0, 0, 0, 0, 5'b11100);
    step("mw_flush1",     0, 0, 0, 0, 0, 1, 0, 0, 5'b11111);
    step("mw_freeze1",    0, 0, 0, 0, 0, 0, 0, 1, 5'b00000);
    step("mw_freeze2",    0, 0, 0, 0, 0, 0, 0, 1, 5'b00000);
    step("mw_flush2",     0, 0, 0, 0, 0, 0, 0, 0, 5'b11111);
    step("mw_flush3",     0, 0, 0, 0, 0, 0, 0, 0, 5'b11111);
    step("mw_done",       0, 0, 0, 0, 0, 0, 0, 0, 5'b11100);
    step("lum_stall",     1, 5, 5, 0, 0, 0, 0, 0, 5'b00101);
    step("lum_freeze",    1, 5, 5, 0, 0, 0, 0, 1, 5'b00000);
    step("lum_resume",    1, 5, 5, 0, 0, 0, 0, 0, 5'b11100);
    step("mb_over_redir", 0, 0, 0, 0, 0, 1, 0, 1, 5'b00000);
    step("mb_exit_run",   0, 0, 0, 0, 0, 0, 0, 0, 5'b11100);
    counters("totals", 16'd3, 16'd6, 16'd4);
    reset_n = 1'b0;
    #1;
    check("reset2_outs", {11'd0, outs}, 16'b00011);
    tick();
    reset_n = 1'b1;
    step("jr_and_lu",     1, 5, 5, 0, 0, 0, 1, 0, 5'b11111);
    counters("jr_lu_cnt", 16'd0, 16'd1, 16'd0);
    step("jr_no_stall",   1, 5, 5, 0, 0, 0, 0, 0, 5'b11111);
    mr = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset_abort", {11'd0, outs}, 16'b00011);
    tick();
    reset_n = 1'b1;
    step("abort_run",     0, 0, 0, 0, 0, 0, 0, 0, 5'b11100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard sequencer for the 5-stage MIPS core. It detects load-use hazards and taken-branch/JR redirects from EX, and waits on data-memory busy. It drives the PC and IF/ID write enables, the IF/ID flush, and the `flush` input of the ID-stage control-zeroing logic. A small FSM stretches redirect flushes over a configurable number of cycles and freezes the pipeline for memory waits without losing pending redirect state.

## Interface

**Parameters**
- `REDIRECT_CYCLES`, default 1: cycles of front-end flush per redirect. Legal range 1..4.

**Ports**
- `clk` in 1: pipeline clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `IDEX_MemRead` in 1: instruction in EX is a load.
- `IDEX_Rt` in 5: destination register of the load in EX.
- `IFID_Rs` in 5: rs field of the instruction in ID.
- `IFID_Rt` in 5: rt field of the instruction in ID.
- `ID_UsesRt` in 1: the ID instruction reads rt.
- `EX_BranchTaken` in 1: branch resolved taken in EX.
- `EX_JR` in 1: JR executing in EX.
- `mem_busy` in 1: data memory not ready this cycle.
- `PC_Write` out 1: PC load enable.
- `IFID_Write` out 1: IF/ID register enable.
- `IFID_Flush` out 1: clear IF/ID to NOP.
- `flush` out 1: zero ID control signals, inserting a bubble into ID/EX.
- `EXMEM_Write` out 1: ID/EX, EX/MEM and MEM/WB enables.
- `stall_cnt`, `flush_cnt`, `memwait_cnt` out 16 each: performance counters (see Configuration).

## Operation

**Definitions**
- `redirect = EX_BranchTaken | EX_JR`
- `lu_hazard = IDEX_MemRead & (IDEX_Rt != 0) & ((IDEX_Rt == IFID_Rs) | (ID_UsesRt & (IDEX_Rt == IFID_Rt)))`

**Structure**
- States: RUN, LU_STALL, REDIRECT, MEM_WAIT.
- State, a 2-bit redirect counter `rcnt` and a saved-state register `ret_state` are registered.
- Outputs are Mealy: combinational from state and inputs.

**Default output values (no event):** `PC_Write=1`, `IFID_Write=1`, `EXMEM_Write=1`, `IFID_Flush=0`, `flush=0`.

**Event priority each cycle:** `mem_busy` > `redirect` > `lu_hazard`.

**mem_busy (any state)**
- Outputs: all write enables = 0, `IFID_Flush=0`, `flush=0`.
- If not already in MEM_WAIT: `ret_state` ← current state, next state = MEM_WAIT.
- `rcnt` is frozen.
- In MEM_WAIT with `mem_busy=0`: the cycle behaves as `ret_state` would with current inputs.

**redirect (RUN, LU_STALL or REDIRECT, `mem_busy=0`)**
- Outputs: `PC_Write=1`, `IFID_Flush=1`, `flush=1`.
- If `REDIRECT_CYCLES>1`: next state = REDIRECT, `rcnt` ← `REDIRECT_CYCLES-1`.
- Otherwise: next state = RUN.
- A redirect arriving while in REDIRECT reloads `rcnt`.

**REDIRECT state, no new redirect**
- Outputs: `IFID_Flush=1`, `flush=1`, `PC_Write=1`.
- `rcnt` decrements; next state = RUN when `rcnt` reaches 1.

**lu_hazard (RUN only, no higher-priority event)**
- Outputs: `PC_Write=0`, `IFID_Write=0`, `flush=1`.
- Next state = LU_STALL.

**LU_STALL**
- `lu_hazard` is ignored; outputs take default values (unless a higher-priority event applies).
- Next state = RUN.
- This guarantees exactly one bubble per load-use hazard.

**Reset**
- While `reset_n=0`: state = RUN, `rcnt=0`, `ret_state=RUN`.
- Outputs held at `PC_Write=0`, `IFID_Write=0`, `EXMEM_Write=0`, `IFID_Flush=1`, `flush=1`.
- Reset asserted mid-stall or mid-redirect aborts immediately. The first cycle after release is RUN.

## Timing

- Detection-to-effect latency is 0 cycles: outputs react in the same cycle as the inputs.
- Load-use inserts exactly 1 bubble.
- A redirect flushes for `REDIRECT_CYCLES` consecutive cycles, not counting MEM_WAIT cycles.
- A memory wait of N cycles freezes the pipeline for exactly N cycles. No bubble is inserted on exit.
- Simultaneous `redirect` and `lu_hazard`: redirect wins, and no LU_STALL is entered.

## Configuration

- `HAZARD_PERF_EN` defined:
  - `stall_cnt` increments on each lu_hazard stall cycle.
  - `flush_cnt` increments on each cycle with `IFID_Flush=1` outside reset.
  - `memwait_cnt` increments on each `mem_busy` cycle.
  - All three saturate at 16'hFFFF and clear on reset.
- `HAZARD_PERF_EN` undefined: the counters are not built and all three ports are tied to 0.

## Test plan

- **Reset:** hold `reset_n=0` for 3 cycles → `PC_Write=0`, `IFID_Flush=1`, `flush=1`. After release, first RUN cycle gives `PC_Write=1`, `flush=0`.
- **Load-use on rs:** `IDEX_MemRead=1`, `IDEX_Rt=5`, `IFID_Rs=5` → one cycle of `PC_Write=0`, `IFID_Write=0`, `flush=1`, then defaults. Repeat with `IDEX_Rt=0` → no stall.
- **Load-use on rt:** `IDEX_Rt=7`, `IFID_Rt=7`, `ID_UsesRt=0` → no stall. Same with `ID_UsesRt=1` → 1 stall.
- **Redirect stretch:** `REDIRECT_CYCLES=3`, one-cycle `EX_BranchTaken` → `IFID_Flush=flush=1` for exactly 3 cycles.
- **Memory wait during redirect:** with `REDIRECT_CYCLES=3`, `mem_busy=1` for 2 cycles after the first flush cycle → 2 frozen cycles (all enables 0), then 2 more flush cycles.
- **Simultaneous events:** `EX_JR=1` and `lu_hazard` in the same cycle → redirect outputs only, next cycle defaults. With `HAZARD_PERF_EN`, `stall_cnt` stays 0 and `flush_cnt=1`.
